// File: rtl/la_clkctrl_pkg.sv
// ---------------------------------------------------------------------------
// la_clkctrl_pkg
// Shared definitions for the clock-control sequencers.
//   state_e : sequencer FSM state, 3-bit encoded
//   cnt_w() : width of a counter that must hold the values 0..n-1
// ---------------------------------------------------------------------------
package la_clkctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLOSE  = 3'd1,
    FLIP   = 3'd2,
    SETTLE = 3'd3,
    OPEN   = 3'd4,
    DONE   = 3'd5,
    ABORT  = 3'd6
  } state_e;

  // Never returns 0, so a count limit of 1 still gives a legal 1-bit counter.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Widths for the default timing (QCYCLES=4, SCYCLES=4, TMO=64).
  localparam int unsigned QCNT_W_DEF = cnt_w(4);
  localparam int unsigned SCNT_W_DEF = cnt_w(4);
  localparam int unsigned TCNT_W_DEF = cnt_w(64);

endpackage

// File: rtl/la_rrarb2.sv
// ---------------------------------------------------------------------------
// la_rrarb2
// Two-way round-robin arbiter. The pointer names the port with priority;
// when a grant is consumed (adv high while gnt is non-zero) the pointer
// moves to the other port.
//   clk   in  : clock, rising edge
//   reset in  : synchronous active-high reset, pointer -> port 0
//   req   in  : request per port
//   adv   in  : consume the current grant and advance the pointer
//   gnt   out : one-hot grant, combinational from req and the pointer
// ---------------------------------------------------------------------------
module la_rrarb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       adv,
  output logic [1:0] gnt
);

  logic ptr_q;
  logic ptr_d;

  always_comb begin
    gnt = '0;
    if (!ptr_q) begin
      if (req[0])      gnt = 2'b01;
      else if (req[1]) gnt = 2'b10;
    end else begin
      if (req[1])      gnt = 2'b10;
      else if (req[0]) gnt = 2'b01;
    end
  end

  // Granting port 0 hands priority to port 1 and vice versa; gnt[0] is
  // exactly the new pointer value.
  always_comb begin
    ptr_d = ptr_q;
    if (adv && (gnt != 2'b00)) ptr_d = gnt[0];
  end

  always_ff @(posedge clk) begin
    if (reset) ptr_q <= 1'b0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/la_clkinv_ctrl.sv
// ---------------------------------------------------------------------------
// la_clkinv_ctrl
// Sequences the select input of a clock-XOR used as a programmable clock
// inverter. Polarity changes are requested by two ports (0 = software,
// 1 = hardware), arbitrated round-robin, and applied only while the
// downstream clock gate is closed and reports idle, so the inverted clock
// never carries a glitch or runt pulse. Runs on the always-on reference clock.
//   clk       in  : reference clock, rising edge
//   reset     in  : synchronous active-high reset
//   req[1:0]  in  : level request per port, held until its ack
//   pol[1:0]  in  : target polarity per port, sampled at grant
//   ack[1:0]  out : one-cycle completion pulse per port
//   busy      out : sequencer not in IDLE
//   gate_en   out : downstream clock-gate enable (1 = clock passes)
//   gate_idle in  : clock gate output is stopped low
//   inv       out : drives the b input of the clock-XOR
//   err       out : sticky gate_idle timeout flag, cleared only by reset
// ---------------------------------------------------------------------------
module la_clkinv_ctrl
  import la_clkctrl_pkg::*;
#(
  parameter logic        INIT    = 1'b0,
  parameter int unsigned QCYCLES = 4,
  parameter int unsigned SCYCLES = 4,
  parameter int unsigned TMO     = 64,
  parameter string       PROP    = "DEFAULT"
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic [1:0] pol,
  output logic [1:0] ack,
  output logic       busy,
  output logic       gate_en,
  input  logic       gate_idle,
  output logic       inv,
  output logic       err
);

  localparam int unsigned QW = cnt_w(QCYCLES);
  localparam int unsigned SW = cnt_w(SCYCLES);
  localparam int unsigned TW = cnt_w(TMO);

  localparam logic [QW-1:0] QMAX = QW'(QCYCLES - 1);
  localparam logic [SW-1:0] SMAX = SW'(SCYCLES - 1);
  localparam logic [TW-1:0] TMAX = TW'(TMO - 1);

  // PROP is an implementation hint for back-end flows; no logic depends on it.
  if (PROP == "") begin : g_prop_none
  end

  state_e        state_q,   state_d;
  logic          tgt_idx_q, tgt_idx_d;
  logic          tgt_pol_q, tgt_pol_d;
  logic [QW-1:0] qcnt_q,    qcnt_d;
  logic [SW-1:0] scnt_q,    scnt_d;
  logic [TW-1:0] tcnt_q,    tcnt_d;
  logic          inv_q,     inv_d;
  logic          gate_en_q, gate_en_d;
  logic [1:0]    ack_q,     ack_d;
  logic          busy_q,    busy_d;
  logic          err_q,     err_d;

  logic [1:0]    gnt;
  logic          arb_adv;

  la_rrarb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .adv   (arb_adv),
    .gnt   (gnt)
  );

  // All outputs are computed from the next state so that they change on the
  // same edge as the state that owns them (gate_en high in OPEN, ack high in
  // DONE) without any combinational path from the inputs.
  always_comb begin
    state_d   = state_q;
    tgt_idx_d = tgt_idx_q;
    tgt_pol_d = tgt_pol_q;
    qcnt_d    = qcnt_q;
    scnt_d    = scnt_q;
    tcnt_d    = tcnt_q;
    inv_d     = inv_q;
    gate_en_d = gate_en_q;
    ack_d     = '0;
    err_d     = err_q;
    arb_adv   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (gnt != 2'b00) begin
          arb_adv   = 1'b1;
          tgt_idx_d = gnt[1];
          tgt_pol_d = pol[gnt[1]];
          if (pol[gnt[1]] == inv_q) begin
            // Already at the requested polarity: release the requester
            // without touching the gate.
            state_d         = DONE;
            ack_d[gnt[1]]   = 1'b1;
          end else begin
            state_d   = CLOSE;
            gate_en_d = 1'b0;
            qcnt_d    = '0;
            tcnt_d    = '0;
          end
        end
      end

      CLOSE: begin
        gate_en_d = 1'b0;
        // A successful close wins over a timeout landing in the same cycle.
        if (gate_idle && (qcnt_q == QMAX)) begin
          state_d = FLIP;
        end else if (tcnt_q == TMAX) begin
          state_d   = ABORT;
          err_d     = 1'b1;
          gate_en_d = 1'b1;
        end else begin
          // qcnt saturates so a slow gate cannot wrap it past the limit.
          if (qcnt_q != QMAX) qcnt_d = qcnt_q + QW'(1);
          tcnt_d = tcnt_q + TW'(1);
        end
      end

      FLIP: begin
        inv_d   = tgt_pol_q;
        state_d = SETTLE;
        scnt_d  = '0;
      end

      SETTLE: begin
        if (scnt_q == SMAX) begin
          state_d   = OPEN;
          gate_en_d = 1'b1;
        end else begin
          scnt_d = scnt_q + SW'(1);
        end
      end

      OPEN: begin
        state_d          = DONE;
        ack_d[tgt_idx_q] = 1'b1;
      end

      ABORT: begin
        state_d          = DONE;
        ack_d[tgt_idx_q] = 1'b1;
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d   = IDLE;
        gate_en_d = 1'b1;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      tgt_idx_q <= 1'b0;
      tgt_pol_q <= INIT;
      qcnt_q    <= '0;
      scnt_q    <= '0;
      tcnt_q    <= '0;
      inv_q     <= INIT;
      gate_en_q <= 1'b1;
      ack_q     <= '0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tgt_idx_q <= tgt_idx_d;
      tgt_pol_q <= tgt_pol_d;
      qcnt_q    <= qcnt_d;
      scnt_q    <= scnt_d;
      tcnt_q    <= tcnt_d;
      inv_q     <= inv_d;
      gate_en_q <= gate_en_d;
      ack_q     <= ack_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
    end
  end

  assign ack     = ack_q;
  assign busy    = busy_q;
  assign gate_en = gate_en_q;
  assign inv     = inv_q;
  assign err     = err_q;

endmodule

// File: tb/tb_la_clkinv_ctrl.sv
// ---------------------------------------------------------------------------
// tb_la_clkinv_ctrl
// Self-checking bench for la_clkinv_ctrl with default timing
// (INIT=0, QCYCLES=4, SCYCLES=4, TMO=64). A timeline model predicts every
// output from the grant cycle and the cycle the gate became usable; directed
// sequences add hand-computed latency and value checks.
// ---------------------------------------------------------------------------
module tb_la_clkinv_ctrl;

  localparam int QC = 4;
  localparam int SC = 4;
  localparam int TM = 64;

  localparam int K_NULL  = 0;
  localparam int K_CLOSE = 1;
  localparam int K_FLIP  = 2;
  localparam int K_ABORT = 3;

  logic       clk;
  logic       reset;
  logic [1:0] req;
  logic [1:0] pol;
  logic [1:0] ack;
  logic       busy;
  logic       gate_en;
  logic       gate_idle;
  logic       inv;
  logic       err;

  la_clkinv_ctrl #(
    .INIT    (1'b0),
    .QCYCLES (QC),
    .SCYCLES (SC),
    .TMO     (TM),
    .PROP    ("DEFAULT")
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .pol       (pol),
    .ack       (ack),
    .busy      (busy),
    .gate_en   (gate_en),
    .gate_idle (gate_idle),
    .inv       (inv),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- timeline model ----------------
  bit   m_valid = 0;
  bit   m_act   = 0;
  bit   m_rst_edge = 0;
  int   m_kind  = K_NULL;
  int   m_gc    = 0;      // grant cycle
  int   m_t     = 0;      // last CLOSE cycle (gate usable, or timeout)
  int   m_ackc  = -1;     // cycle in which ack is expected
  bit   m_idx   = 0;
  bit   m_pol   = 0;
  bit   m_inv   = 0;
  bit   m_err   = 0;
  bit   m_rr    = 0;

  logic [1:0] e_ack;
  logic       e_busy, e_gate, e_inv, e_err;
  logic       prev_inv, prev_gate;
  bit         have_prev = 0;

  initial begin
    forever begin
      @(posedge clk);
      m_rst_edge = reset;
      if (reset) begin
        m_valid = 1; m_act = 0; m_inv = 1'b0; m_err = 0; m_rr = 0;
      end else if (m_valid) begin
        if (m_act && cyc == m_ackc) begin
          m_act = 0;
          if (m_kind == K_FLIP) m_inv = m_pol;
        end else if (!m_act) begin
          if (req != 2'b00) begin
            m_idx = req[m_rr] ? m_rr : !m_rr;
            m_rr  = !m_idx;
            m_pol = pol[m_idx];
            m_act = 1;
            m_gc  = cyc;
            if (m_pol == m_inv) begin
              m_kind = K_NULL;  m_ackc = cyc + 1;
            end else begin
              m_kind = K_CLOSE; m_ackc = -1;
            end
          end
        end else if (m_kind == K_CLOSE) begin
          if (gate_idle && (cyc - m_gc) >= QC) begin
            m_kind = K_FLIP;  m_t = cyc; m_ackc = cyc + SC + 3;
          end else if ((cyc - m_gc) == TM) begin
            m_kind = K_ABORT; m_t = cyc; m_ackc = cyc + 2; m_err = 1;
          end
        end
      end
      cyc++;
      // expectations for the cycle that has just begun
      e_busy = m_act;
      e_ack  = (m_act && cyc == m_ackc) ? (m_idx ? 2'b10 : 2'b01) : 2'b00;
      e_gate = 1'b1;
      if (m_act && m_kind == K_CLOSE) e_gate = 1'b0;
      if (m_act && m_kind == K_FLIP && cyc <= m_t + 1 + SC) e_gate = 1'b0;
      e_inv  = (m_act && m_kind == K_FLIP && cyc >= m_t + 2) ? m_pol : m_inv;
      e_err  = m_err;

      @(negedge clk);
      if (m_valid) begin
        chk("ack",     int'(ack),     int'(e_ack));
        chk("busy",    int'(busy),    int'(e_busy));
        chk("gate_en", int'(gate_en), int'(e_gate));
        chk("inv",     int'(inv),     int'(e_inv));
        chk("err",     int'(err),     int'(e_err));
        if (have_prev && !m_rst_edge)
          chk("inv_change_with_gate_open",
              int'((inv != prev_inv) && (gate_en || prev_gate)), 0);
        prev_inv  = inv;
        prev_gate = gate_en;
        have_prev = 1;
      end
    end
  end

  // ---------------- stimulus ----------------
  // Raises req[idx] in "cycle 0" and returns the number of cycles until
  // ack[idx] is seen (-1 if it never comes within max_cyc). gi_low drops
  // gate_idle from cycle 0; gi_rise>0 raises it again in that cycle.
  task automatic run_req(input int idx, input bit pv, input bit gi_low,
                         input int gi_rise, input int max_cyc, output int lat);
    @(negedge clk);
    req[idx] = 1'b1;
    pol[idx] = pv;
    if (gi_low) gate_idle = 1'b0;
    lat = -1;
    for (int n = 1; n <= max_cyc && lat < 0; n++) begin
      @(negedge clk);
      if (ack[idx]) begin
        lat = n;
        req[idx] = 1'b0;
      end
      if (gi_rise == n) gate_idle = 1'b1;
    end
    req[idx]  = 1'b0;
    gate_idle = 1'b1;
  endtask

  task automatic gap(input int n);
    repeat (n) @(negedge clk);
  endtask

  int lat;
  int a_cyc[3];
  int a_val[3];
  int n_ack;

  initial begin
    reset = 1'b1; req = 2'b00; pol = 2'b00; gate_idle = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_inv",     int'(inv), 0);
    chk("rst_gate_en", int'(gate_en), 1);
    chk("rst_busy",    int'(busy), 0);
    chk("rst_ack",     int'(ack), 0);
    chk("rst_err",     int'(err), 0);
    gap(2);

    // basic flip, port 0 -> inverted
    run_req(0, 1'b1, 1'b0, 0, 200, lat);
    chk("basic_latency", lat, QC + SC + 3);
    chk("basic_inv", int'(inv), 1);
    gap(1);
    chk("basic_busy_after", int'(busy), 0);
    gap(2);

    // null request, port 1 already matches
    run_req(1, 1'b1, 1'b0, 0, 50, lat);
    chk("null_latency", lat, 1);
    chk("null_gate_en", int'(gate_en), 1);
    chk("null_inv", int'(inv), 1);
    gap(2);

    // slow gate: idle rises 20 cycles after gate_en falls (cycle 1 -> 21)
    run_req(0, 1'b0, 1'b1, 21, 200, lat);
    chk("slow_latency", lat, 28);
    chk("slow_err", int'(err), 0);
    chk("slow_inv", int'(inv), 0);
    gap(2);

    // timeout: gate never idles
    run_req(1, 1'b1, 1'b1, 0, 200, lat);
    chk("tmo_latency", lat, TM + 2);
    chk("tmo_err", int'(err), 1);
    chk("tmo_inv", int'(inv), 0);
    chk("tmo_gate_en", int'(gate_en), 1);
    gap(2);

    // err stays sticky across a good sequence
    run_req(0, 1'b1, 1'b0, 0, 200, lat);
    chk("post_tmo_latency", lat, QC + SC + 3);
    chk("post_tmo_err", int'(err), 1);
    chk("post_tmo_inv", int'(inv), 1);
    gap(2);

    // reset in the middle of SETTLE (cycle 7)
    @(negedge clk);
    req[1] = 1'b1; pol[1] = 1'b0;
    gap(7);
    reset = 1'b1; req[1] = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_inv",     int'(inv), 0);
    chk("midrst_gate_en", int'(gate_en), 1);
    chk("midrst_busy",    int'(busy), 0);
    chk("midrst_ack",     int'(ack), 0);
    chk("midrst_err",     int'(err), 0);
    gap(15);

    run_req(0, 1'b1, 1'b0, 0, 200, lat);
    chk("fresh_latency", lat, QC + SC + 3);
    chk("fresh_inv", int'(inv), 1);
    gap(2);
    run_req(1, 1'b0, 1'b0, 0, 200, lat);
    chk("back_latency", lat, QC + SC + 3);
    chk("back_inv", int'(inv), 0);
    gap(2);

    // contention: both held, pointer at port 0
    @(negedge clk);
    req = 2'b11; pol = 2'b01;
    n_ack = 0;
    for (int i = 0; i < 3; i++) begin a_cyc[i] = -1; a_val[i] = -1; end
    for (int n = 1; n <= 120 && n_ack < 3; n++) begin
      @(negedge clk);
      if (ack != 2'b00) begin
        a_cyc[n_ack] = n;
        a_val[n_ack] = int'(ack);
        n_ack++;
        if (n_ack == 3) req = 2'b00;
      end
    end
    req = 2'b00;
    chk("cont_ack0_cycle", a_cyc[0], 11);
    chk("cont_ack0_port",  a_val[0], 1);
    chk("cont_ack1_cycle", a_cyc[1], 23);
    chk("cont_ack1_port",  a_val[1], 2);
    chk("cont_ack2_cycle", a_cyc[2], 35);
    chk("cont_ack2_port",  a_val[2], 1);
    chk("cont_inv", int'(inv), 1);
    gap(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected completion before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/la_clkinv_ctrl.md
Name: la_clkinv_ctrl

Overview:
- Sequencer for the select input of a 2-input clock XOR used as a programmable clock inverter.
- Arbitrates polarity-change requests from two requesters: port 0 is software configuration, port 1 is hardware (DFT or calibration).
- Every polarity flip happens while the downstream clock gate is closed, so no glitch or runt pulse reaches the clock tree.
- Sits beside the clock-XOR cell in the clock-generation block. Its clock is the always-on reference clock, not the clock being inverted.

Parameters:
- INIT, 1'b0, polarity driven on inv after reset (1 = inverted).
- QCYCLES, 4, minimum cycles gate held closed before the flip (1..255).
- SCYCLES, 4, cycles after the flip before the gate reopens (1..255).
- TMO, 64, maximum cycles waiting for gate_idle before error (2..65535).
- PROP, "DEFAULT", implementation property passthrough.

Ports:
- clk  input  1  reference clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  2  level request per requester; held until the matching ack.
- pol  input  2  target polarity per requester; sampled at grant.
- ack  output  2  one-cycle completion pulse per requester.
- busy  output  1  high whenever state is not IDLE.
- gate_en  output  1  enable to the downstream clock gate (1 = clock passes).
- gate_idle  input  1  clock gate reports its output is stopped low.
- inv  output  1  drives the b input of the clock-XOR cell.
- err  output  1  sticky; set on gate_idle timeout, cleared only by reset.

Behaviour:
- Reset values: inv=INIT, gate_en=1, ack=0, busy=0, err=0, state=IDLE, round-robin pointer=0, counters=0.
- Reset asserted mid-sequence aborts the sequence: inv returns to INIT, gate_en returns to 1 on the next edge, no ack is issued.
- Arbitration (IDLE only):
  - Round-robin between req[0] and req[1]; the pointer names the higher-priority port.
  - On grant, the pointer moves to the other port.
  - When both ports request with pointer=0, port 0 is granted.
  - The granted index and pol[g] are latched into tgt.
- Null request: if tgt equals the current inv, go to DONE directly. gate_en stays 1 and inv is unchanged.
- FSM states and transitions:
  - IDLE: wait for any req.
  - CLOSE: gate_en=0; qcnt counts up from 0. Go to FLIP when gate_idle=1 and qcnt>=QCYCLES-1. If tcnt reaches TMO-1 first, set err and go to ABORT.
  - FLIP: one cycle; inv<=tgt, registered. Go to SETTLE.
  - SETTLE: scnt counts SCYCLES cycles. gate_en stays 0 throughout. Then go to OPEN.
  - OPEN: gate_en<=1. Next cycle go to DONE.
  - DONE: ack[g]=1 for exactly one cycle. Go to IDLE.
  - ABORT: inv unchanged, gate_en<=1. Go to DONE, which still issues ack so the requester is released.
- Latency:
  - Flipping request: req sampled in IDLE at cycle 0; ack is high exactly QCYCLES+SCYCLES+3 cycles later, provided gate_idle is already 1.
  - Null request: ack is high 1 cycle later.
- A requester that keeps req high after its ack is treated as a new request. It competes again in IDLE through the round-robin pointer.
- Changes on pol or req during a sequence are ignored until IDLE.
- inv and gate_en are registered outputs with no combinational path from inputs. inv never changes while gate_en=1.
- Counter widths are derived with $clog2 from the parameters. qcnt and tcnt reset on entry to CLOSE; scnt resets on entry to SETTLE.

Decomposition:
- Shared package la_clkctrl_pkg holds:
  - the FSM state enum (IDLE, CLOSE, FLIP, SETTLE, OPEN, DONE, ABORT), 3 bits;
  - localparam helpers for counter widths.
- One natural sub-module: la_rrarb2, a 2-way round-robin arbiter (req, advance strobe, one-hot grant, pointer register). It is reused by other clock controllers.

Test Plan:
- Basic flip: reset, INIT=0, gate_idle=1, req=2'b01, pol[0]=1 -> gate_en falls next cycle, inv=1 after 4 CLOSE cycles, gate_en=1 after 4 SETTLE cycles, ack=2'b01 at cycle 11, busy low at cycle 12.
- Null request: inv=1, req[1]=1, pol[1]=1 -> ack[1] pulses 1 cycle later; gate_en stays 1; inv unchanged.
- Contention: req=2'b11 held with pol=2'b01 -> port 0 served first (inv=1, ack[0]), then port 1 (inv=0, ack[1]); port 0 re-requested is served after port 1; no ack overlap.
- Slow gate: gate_idle rises 20 cycles after gate_en falls -> flip occurs on the cycle after gate_idle rises; ack is delayed accordingly; err stays 0.
- Timeout: gate_idle held 0 -> err=1 after 64 CLOSE cycles, inv unchanged, gate_en=1, ack issued; err remains set through later successful requests.
- Reset mid-SETTLE: pulse reset for 1 cycle -> next edge gives inv=INIT, gate_en=1, busy=0, no ack; a fresh request then completes normally.
